_arb_muxn: RTL and testbench

//   m-input, n-bit arbitrated multiplexer with a registered output and valid/ready handshake.

---
 rtl/_arb_muxn_if.sv | 33 +++
 rtl/_arb_muxn.sv | 98 +++++++++
 tb/tb__arb_muxn.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/_arb_muxn_if.sv
// Handshake bundle for the arbitrated multiplexer.
//   in_valid  [m]    per-channel word present
//   in_data   [m*n]  channel i word at in_data[i*n +: n]
//   in_ready  [m]    one-hot (or zero) accept strobe back to the channels
//   out_valid        output register holds a word
//   out_data  [n]    held word
//   out_src   [SW]   channel index the held word came from
//   out_ready        consumer takes the held word this cycle
// master: the requesters/consumer side; slave: the multiplexer.
interface _arb_muxn_if #(
    parameter int n = 8,
    parameter int m = 4
);
    localparam int SW = $clog2(m);

    logic [m-1:0]   in_valid;
    logic [m*n-1:0] in_data;
    logic [m-1:0]   in_ready;
    logic           out_valid;
    logic [n-1:0]   out_data;
    logic [SW-1:0]  out_src;
    logic           out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/_arb_muxn.sv
// m-input, n-bit arbitrated multiplexer with a one-deep registered output.
// Channels present words with in_valid; the arbiter picks one (round-robin
// for MODE 0, lowest index for MODE 1), strobes its in_ready and loads the
// word into the output register whenever that register is empty or being
// popped in the same cycle.
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  _arb_muxn_if slave modport (channel inputs, output word, handshakes)
module _arb_muxn #(
    parameter int n    = 8,
    parameter int m    = 4,
    parameter int MODE = 0
) (
    input logic        clk,
    input logic        rst,
    _arb_muxn_if.slave bus
);
    localparam int SW = $clog2(m);

    logic          out_valid_q;
    logic [n-1:0]  out_data_q;
    logic [SW-1:0] out_src_q;
    logic [SW-1:0] ptr_q;

    logic [SW-1:0] ptr_eff;
    logic [SW-1:0] hi_idx;
    logic [SW-1:0] lo_idx;
    logic          hi_found;
    logic          lo_found;
    logic          any_valid;
    logic [SW-1:0] g;
    logic          load;
    logic          grant_ok;
    logic [n-1:0]  sel_data;

    assign load     = !out_valid_q || bus.out_ready;
    assign grant_ok = load && !rst && any_valid;

    // Round-robin split: the lowest requester at or above ptr wins; if there
    // is none, the lowest requester below ptr wins (the wrapped part of the scan).
    // Fixed priority is the same search with the pointer pinned at 0.
    always_comb begin
        ptr_eff  = (MODE == 0) ? ptr_q : '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = m - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
                if (SW'(i) >= ptr_eff) begin
                    hi_found = 1'b1;
                    hi_idx   = SW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = SW'(i);
                end
            end
        end
        any_valid = hi_found || lo_found;
        g         = hi_found ? hi_idx : lo_idx;
    end

    // AND-OR select so data on non-granted channels (including X) never reaches the output.
    always_comb begin
        sel_data     = '0;
        bus.in_ready = '0;
        for (int i = 0; i < m; i++) begin
            if (g == SW'(i)) begin
                sel_data        = bus.in_data[i*n +: n];
                bus.in_ready[i] = grant_ok;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= '0;
        end else if (load) begin
            if (any_valid) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sel_data;
                out_src_q   <= g;
                if (MODE == 0) begin
                    ptr_q <= (g == SW'(m - 1)) ? '0 : g + 1'b1;
                end
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb__arb_muxn.sv
module tb__arb_muxn;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut 0: MODE 0, m=4   dut 1: MODE 1, m=4   dut 2: MODE 0, m=3
    _arb_muxn_if #(.n(8), .m(4)) if0 ();
    _arb_muxn_if #(.n(8), .m(4)) if1 ();
    _arb_muxn_if #(.n(8), .m(3)) if2 ();

    _arb_muxn #(.n(8), .m(4), .MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    _arb_muxn #(.n(8), .m(4), .MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    _arb_muxn #(.n(8), .m(3), .MODE(0)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    logic [3:0]  iv = 4'hF;
    logic [2:0]  ordy = 3'b111;
    logic [31:0] dat01 [2];
    logic [23:0] dat2 = '0;

    assign if0.in_valid  = iv;
    assign if0.in_data   = dat01[0];
    assign if0.out_ready = ordy[0];
    assign if1.in_valid  = iv;
    assign if1.in_data   = dat01[1];
    assign if1.out_ready = ordy[1];
    assign if2.in_valid  = iv[2:0];
    assign if2.in_data   = dat2;
    assign if2.out_ready = ordy[2];

    logic [3:0] rdy [3];
    logic       ov  [3];
    logic [7:0] od  [3];
    logic [1:0] os  [3];
    assign rdy[0] = if0.in_ready;
    assign rdy[1] = if1.in_ready;
    assign rdy[2] = {1'b0, if2.in_ready};
    assign ov[0] = if0.out_valid;  assign od[0] = if0.out_data;  assign os[0] = if0.out_src;
    assign ov[1] = if1.out_valid;  assign od[1] = if1.out_data;  assign os[1] = if1.out_src;
    assign ov[2] = if2.out_valid;  assign od[2] = if2.out_data;  assign os[2] = if2.out_src;

    // Reference model: per-dut output word, source, and round-robin pointer.
    int MM [3] = '{4, 4, 3};
    int MD [3] = '{0, 1, 0};
    bit         mv [3];
    logic [7:0] md [3];
    int         ms [3];
    int         mp [3];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scan starting at p, wrapping modulo mm; -1 when nobody requests.
    function automatic int pick(input logic [3:0] v, input int mm, input int p);
        for (int k = 0; k < mm; k++)
            if (v[(p + k) % mm]) return (p + k) % mm;
        return -1;
    endfunction

    function automatic logic [7:0] getb(input int d, input int g);
        if (d < 2) return dat01[d][g*8 +: 8];
        return dat2[g*8 +: 8];
    endfunction

    task automatic step(input logic [3:0] v, input logic [2:0] o, input logic r, input bit a5);
        int gv [3];
        bit ldv [3];
        logic [3:0] vm;
        logic [3:0] er;
        @(negedge clk);
        iv = v; ordy = o; rst = r;
        dat01[0] = a5 ? 32'hA5A5A5A5 : $urandom;
        dat01[1] = a5 ? 32'hA5A5A5A5 : $urandom;
        dat2     = a5 ? 24'hA5A5A5 : 24'($urandom);
        #1;
        for (int d = 0; d < 3; d++) begin
            vm = (d == 2) ? {1'b0, v[2:0]} : v;
            ldv[d] = !mv[d] || o[d];
            gv[d] = pick(vm, MM[d], mp[d]);
            er = (ldv[d] && !r && gv[d] >= 0) ? (4'b1 << gv[d]) : 4'b0;
            check($sformatf("d%0d.in_ready", d), 32'(rdy[d]), 32'(er));
            check($sformatf("d%0d.out_valid", d), 32'(ov[d]), 32'(mv[d]));
            check($sformatf("d%0d.out_data", d), 32'(od[d]), 32'(md[d]));
            check($sformatf("d%0d.out_src", d), 32'(os[d]), 32'(ms[d]));
        end
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (r) begin
                mv[d] = 0; md[d] = '0; ms[d] = 0; mp[d] = 0;
            end else if (ldv[d]) begin
                if (gv[d] >= 0) begin
                    mv[d] = 1;
                    md[d] = getb(d, gv[d]);
                    ms[d] = gv[d];
                    if (MD[d] == 0) mp[d] = (gv[d] == MM[d] - 1) ? 0 : gv[d] + 1;
                end else begin
                    mv[d] = 0;
                end
            end
        end
    endtask

    initial begin
        dat01[0] = '0;
        dat01[1] = '0;
        for (int d = 0; d < 3; d++) begin
            mv[d] = 0; md[d] = '0; ms[d] = 0; mp[d] = 0;
        end
        @(posedge clk);

        // reset held with all channels requesting
        step(4'hF, 3'b111, 1'b1, 0);
        step(4'hF, 3'b111, 1'b1, 0);

        // all requesting, free-flowing output: rotating grants
        for (int k = 0; k < 8; k++) begin
            step(4'hF, 3'b111, 1'b0, 0);
            #1;
            check("rr4_seq", 32'(os[0]), 32'(k % 4));
            check("rr3_seq", 32'(os[2]), 32'(k % 3));
        end

        // pointer to 3, then only 0 and 1 request: 0,1,0
        step(4'b0100, 3'b111, 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            step(4'b0011, 3'b111, 1'b0, 0);
            #1;
            check("wrap_seq", 32'(os[0]), 32'(k % 2));
        end

        // backpressure: hold A5 for 5 cycles, then release
        step(4'hF, 3'b111, 1'b0, 1);
        for (int k = 0; k < 5; k++) begin
            step(4'hF, 3'b000, 1'b0, 0);
            check("stall_data", 32'(od[0]), 32'hA5);
        end
        step(4'hF, 3'b111, 1'b0, 0);

        // fixed priority: channel 1 wins over 3 until it drops
        for (int k = 0; k < 4; k++) begin
            step(4'b1010, 3'b111, 1'b0, 0);
            #1;
            check("prio_src", 32'(os[1]), 32'd1);
        end
        step(4'b1000, 3'b111, 1'b0, 0);
        #1;
        check("prio_low", 32'(os[1]), 32'd3);

        // bubble, then reset while holding a word
        step(4'h0, 3'b111, 1'b0, 0);
        step(4'h0, 3'b111, 1'b0, 0);
        step(4'hF, 3'b111, 1'b0, 0);
        step(4'hF, 3'b111, 1'b0, 0);
        step(4'hF, 3'b000, 1'b1, 0);
        step(4'hF, 3'b111, 1'b0, 0);
        #1;
        check("post_rst_src", 32'(os[0]), 32'd0);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            step(4'($urandom), 3'($urandom), ($urandom_range(0, 39) == 0), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
